// File: rtl/parity_rx_pkg.sv
// parity_rx_pkg: shared state encoding and line-level constants for the parity frame receiver.
package parity_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/parity_calc8.sv
// parity_calc8: even-parity bit of a byte (XOR of all eight bits).
module parity_calc8 (
    input  logic [7:0] data_i,
    output logic       parity_o
);

    assign parity_o = ^data_i;

endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: start/8 data/even parity/stop deserializer with a one-entry
// valid/ready output register carrying parity and framing error flags.
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxLine,
    output logic [7:0] outData,
    output logic       outValid,
    input  logic       outReady,
    output logic       outParityError,
    output logic       outFrameError,
    output logic       overrun,
    output logic       busy
);

    localparam int           CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_e          state_q;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [7:0]      data_q;
    logic            valid_q, perr_q, ferr_q, ovr_q, busy_q;
    logic            data_par, line, done, can_load;

    parity_calc8 u_calc (
        .data_i  (shift_q),
        .parity_o(data_par)
    );

    assign line     = sync2_q;
    assign done     = (state_q == STOP) && (cnt_q == LAST);
    // The held byte may be replaced in the same cycle it is accepted.
    assign can_load = !valid_q || outReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rxLine;
            sync2_q <= sync1_q;
            ovr_q   <= 1'b0;
            cnt_q   <= (state_q == IDLE || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            if (valid_q && outReady)
                valid_q <= 1'b0;
            if (done && can_load) begin
                data_q  <= shift_q;
                perr_q  <= data_par ^ par_q;
                ferr_q  <= line != STOP_LEVEL;
                valid_q <= 1'b1;
            end else if (done) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (line == START_LEVEL) begin
                    cnt_q   <= '0;
                    state_q <= START;
                    busy_q  <= 1'b1;
                end
                START: if (cnt_q == MID) begin
                    cnt_q   <= '0;
                    state_q <= (line == START_LEVEL) ? DATA : IDLE;
                    busy_q  <= line == START_LEVEL;
                end
                DATA: if (cnt_q == LAST) begin
                    shift_q <= {line, shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_q   <= '0;
                        state_q <= PARITY;
                    end
                end
                PARITY: if (cnt_q == LAST) begin
                    par_q   <= line;
                    state_q <= STOP;
                end
                STOP: if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign outData        = data_q;
    assign outValid       = valid_q;
    assign outParityError = perr_q;
    assign outFrameError  = ferr_q;
    assign overrun        = ovr_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed and random frames checked cycle by cycle against a
// frame-level model of the receiver's output register.
module tb_parity_frame_rx;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 10 * CPB;

    logic       clk = 1'b0;
    logic       reset, rxLine, outReady;
    logic [7:0] outData;
    logic       outValid, outParityError, outFrameError, overrun, busy;
    logic [7:0] tb_byte;
    logic       tb_par;

    int n_assert = 0;
    int n_fail   = 0;

    bit         m_valid, m_perr, m_ferr, p_perr, p_ferr;
    logic [7:0] m_data, p_data;

    always #5 clk = ~clk;

    parity_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxLine        (rxLine),
        .outData       (outData),
        .outValid      (outValid),
        .outReady      (outReady),
        .outParityError(outParityError),
        .outFrameError (outFrameError),
        .overrun       (overrun),
        .busy          (busy)
    );

    parity_calc8 u_gen (
        .data_i  (tb_byte),
        .parity_o(tb_par)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive ready, then apply the output-register rules at the edge.
    task automatic tick(input bit rdy, input bit done_now);
        bit exp_ovr;
        outReady = rdy;
        @(negedge clk);
        exp_ovr = 1'b0;
        if (done_now && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_data  = p_data;
            m_perr  = p_perr;
            m_ferr  = p_ferr;
        end else if (done_now) begin
            exp_ovr = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        chk("valid", outValid, m_valid);
        chk("overrun", overrun, exp_ovr);
        if (m_valid) begin
            chk("data", outData, m_data);
            chk("perr", outParityError, m_perr);
            chk("ferr", outFrameError, m_ferr);
        end
    endtask

    function automatic bit rdy_for(input int rmode, input int c);
        return rmode == 1 || (rmode == 2 && $urandom_range(0, 1) == 1) || (rmode == 3 && c == LAT);
    endfunction

    task automatic idle(input int n, input int rmode);
        rxLine = 1'b1;
        for (int i = 0; i < n; i++)
            tick(rdy_for(rmode, -1), 1'b0);
    endtask

    task automatic reset_check();
        reset    = 1'b1;
        rxLine   = 1'b1;
        outReady = 1'b0;
        @(negedge clk);
        m_valid = 1'b0;
        chk("rst_data", outData, 0);
        chk("rst_valid", outValid, 0);
        chk("rst_perr", outParityError, 0);
        chk("rst_ferr", outFrameError, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
    endtask

    // par: 0/1 explicit parity bit, 2 correct parity, 3 inverted parity.
    task automatic send_frame(input logic [7:0] d, input int par, input bit stp,
                              input int rmode, input int abort_at);
        bit pb = 1'b0;
        tb_byte = d;
        p_data  = d;
        p_ferr  = !stp;
        for (int c = 0; c < 11 * CPB; c++) begin
            int slot = c / CPB;
            if (c == abort_at) begin
                reset_check();
                return;
            end
            if (slot == 9 && c % CPB == 0) begin
                pb     = (par < 2) ? par[0] : (tb_par ^ (par == 3));
                p_perr = ($countones({d, pb}) % 2) == 1;
            end
            rxLine = (slot == 0) ? 1'b0 : (slot < 9) ? d[slot-1] : (slot == 9) ? pb : stp;
            tick(rdy_for(rmode, c), c == LAT);
            chk("busy", busy, (c >= 2 && c < LAT) || (!stp && c > LAT));
        end
    endtask

    initial begin
        reset    = 1'b1;
        rxLine   = 1'b1;
        outReady = 1'b0;
        tb_byte  = '0;
        m_valid  = 1'b0;
        repeat (3) @(negedge clk);
        reset_check();
        idle(10, 1);

        send_frame(8'hA5, 0, 1'b1, 0, -1);
        idle(20, 1);
        send_frame(8'h07, 0, 1'b1, 1, -1);
        idle(20, 1);
        send_frame(8'h3C, 0, 1'b0, 1, -1);
        idle(40, 1);
        send_frame(8'h81, 0, 1'b1, 1, -1);
        idle(20, 1);

        for (int c = 0; c < 40; c++) begin
            rxLine = (c < 5) ? 1'b0 : 1'b1;
            tick(1'b1, 1'b0);
            chk("glitch_busy", busy, c >= 2 && c < 2 + CPB / 2);
        end

        send_frame(8'h11, 2, 1'b1, 0, -1);
        idle(5, 0);
        send_frame(8'h22, 2, 1'b1, 0, -1);
        idle(5, 0);
        send_frame(8'h22, 2, 1'b1, 3, -1);
        idle(5, 0);
        idle(20, 1);

        send_frame(8'hC3, 2, 1'b1, 0, -1);
        send_frame(8'h96, 2, 1'b1, 0, 4 * CPB + CPB / 2);
        idle(10, 1);
        send_frame(8'h5A, 2, 1'b1, 1, -1);
        idle(20, 1);

        for (int f = 0; f < 30; f++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? 3 : 2,
                       $urandom_range(0, 3) != 0, int'($urandom_range(0, 2)), -1);
            idle(int'($urandom_range(CPB, 3 * CPB)), 2);
        end
        idle(10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
